// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared screen constants, axis state type and coordinate clamp.
// Revision : 1.0
// ============================================================================
package sprite_pkg;

    localparam int VGA_W = 640;
    localparam int VGA_H = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2
    } axis_state_e;

    function automatic int clamp_coord(input int value, input int limit);
        if (value < 0) begin
            return 0;
        end else if (value > limit) begin
            return limit;
        end else begin
            return value;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_axis_motion.sv
`default_nettype none
// ============================================================================
// Module   : sprite_axis_motion
// Purpose  : One motion axis: accelerate/cruise FSM, speed, hold and position.
// Revision : 1.0
// ============================================================================
module sprite_axis_motion
    import sprite_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int LIMIT       = 608,
    parameter int START       = 304,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               freeze_i,
    input  logic               neg_i,
    input  logic               pos_i,
    output logic [COORD_W-1:0] pos_o,
    output axis_state_e        state_o
);

    localparam int SPEED_W = $clog2(MAX_SPEED + 1);
    localparam int HOLD_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_ONE  = SPEED_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(ACCEL_TICKS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam axis_state_e        PRESS_STATE = (MAX_SPEED == 1) ? CRUISE : ACCEL;

    axis_state_e           state_q, state_d;
    logic [SPEED_W-1:0]    speed_q, speed_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic signed [1:0]     last_dir_q, last_dir_d;
    logic [COORD_W-1:0]    pos_q, pos_d;

    logic signed [1:0]         w_dir;
    logic signed [COORD_W+1:0] w_base;
    logic signed [COORD_W+1:0] w_step;
    logic signed [COORD_W+1:0] w_sum;
    int                        w_clamped;

    always_comb begin
        if (neg_i && !pos_i) begin
            w_dir = -2'sd1;
        end else if (pos_i && !neg_i) begin
            w_dir = 2'sd1;
        end else begin
            w_dir = 2'sd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        hold_d     = hold_q;
        last_dir_d = last_dir_q;
        pos_d      = pos_q;
        w_base     = $signed({2'b00, pos_q});
        w_step     = '0;
        w_sum      = w_base;
        w_clamped  = 0;
        if (tick_i) begin
            last_dir_d = w_dir;
            if (freeze_i || (w_dir == 2'sd0)) begin
                speed_d = '0;
                hold_d  = '0;
                state_d = IDLE;
            end else if ((state_q == IDLE) || (w_dir != last_dir_q)) begin
                speed_d = SPEED_ONE;
                hold_d  = '0;
                state_d = PRESS_STATE;
            end else if (state_q == ACCEL) begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    speed_d = speed_q + SPEED_ONE;
                    if (speed_d == SPEED_MAX) begin
                        state_d = CRUISE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end else begin
                speed_d = SPEED_MAX;
            end
            // Move by this tick's speed so a fresh press moves 1 px immediately.
            w_step = $signed({{(COORD_W + 2 - SPEED_W){1'b0}}, speed_d});
            w_sum  = w_dir[1] ? (w_base - w_step) : (w_base + w_step);
            w_clamped = clamp_coord(int'(w_sum), LIMIT);
            pos_d     = COORD_W'(w_clamped);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            speed_q    <= '0;
            hold_q     <= '0;
            last_dir_q <= 2'sd0;
            pos_q      <= COORD_W'(START);
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            hold_q     <= hold_d;
            last_dir_q <= last_dir_d;
            pos_q      <= pos_d;
        end
    end

    assign pos_o   = pos_q;
    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/sprite_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : sprite_motion_controller
// Purpose  : Button synchronisers, motion tick, two axes and edge flags.
// Revision : 1.0
// ============================================================================
module sprite_motion_controller
    import sprite_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int SCREEN_W    = VGA_W,
    parameter int SCREEN_H    = VGA_H,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int START_X     = 304,
    parameter int START_Y     = 400,
    parameter int TICK_DIV    = 131072,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8
) (
    input  logic               clk25,
    input  logic               rst_n,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               freeze,
    output logic [COORD_W-1:0] sprite_x,
    output logic [COORD_W-1:0] sprite_y,
    output logic               moving,
    output logic [3:0]         at_edge
);

    localparam int LIMIT_X = SCREEN_W - SPRITE_W;
    localparam int LIMIT_Y = SCREEN_H - SPRITE_H;
    localparam int CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit order {down, up, right, left}
    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_tick;
    axis_state_e      w_state_x, w_state_y;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {btn_down, btn_up, btn_right, btn_left};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign w_tick = (cnt_q == CNT_LAST);
    assign cnt_d  = w_tick ? '0 : (cnt_q + CNT_ONE);

    sprite_axis_motion #(
        .COORD_W    (COORD_W),
        .LIMIT      (LIMIT_X),
        .START      (START_X),
        .MAX_SPEED  (MAX_SPEED),
        .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis_x (
        .clk     (clk25),
        .rst_n   (rst_n),
        .tick_i  (w_tick),
        .freeze_i(freeze),
        .neg_i   (sync2_q[0]),
        .pos_i   (sync2_q[1]),
        .pos_o   (sprite_x),
        .state_o (w_state_x)
    );

    sprite_axis_motion #(
        .COORD_W    (COORD_W),
        .LIMIT      (LIMIT_Y),
        .START      (START_Y),
        .MAX_SPEED  (MAX_SPEED),
        .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis_y (
        .clk     (clk25),
        .rst_n   (rst_n),
        .tick_i  (w_tick),
        .freeze_i(freeze),
        .neg_i   (sync2_q[2]),
        .pos_i   (sync2_q[3]),
        .pos_o   (sprite_y),
        .state_o (w_state_y)
    );

    assign moving  = (w_state_x != IDLE) || (w_state_y != IDLE);
    assign at_edge = {sprite_y == COORD_W'(LIMIT_Y),
                      sprite_y == '0,
                      sprite_x == COORD_W'(LIMIT_X),
                      sprite_x == '0};

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_motion_controller
// Purpose  : Directed and random motion checks against a run-length model.
// Revision : 1.0
// ============================================================================
module tb_sprite_motion_controller;
    import sprite_pkg::*;

    localparam int TDIV  = 4;
    localparam int MAXS  = 3;
    localparam int ACCT  = 2;
    localparam int LIM_X = 608;
    localparam int LIM_Y = 448;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       btn_left, btn_right, btn_up, btn_down, freeze;
    logic [9:0] sprite_x, sprite_y;
    logic       moving;
    logic [3:0] at_edge;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: n = consecutive ticks the current direction has been held
    int m_x = 304, m_y = 400;
    int n_x = 0,   n_y = 0;
    int ld_x = 0,  ld_y = 0;
    int st_x = 0,  st_y = 0;

    always #5 clk25 = ~clk25;

    sprite_motion_controller #(
        .TICK_DIV   (TDIV),
        .MAX_SPEED  (MAXS),
        .ACCEL_TICKS(ACCT)
    ) u_dut (
        .clk25    (clk25),
        .rst_n    (rst_n),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .freeze   (freeze),
        .sprite_x (sprite_x),
        .sprite_y (sprite_y),
        .moving   (moving),
        .at_edge  (at_edge)
    );

    task automatic check_value(input string tag, input int obs, input int exp);
        n_compared++;
        if (obs != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_axis(input int dir, input bit frz, input int lim,
                              inout int n, inout int ld, inout int pos, output int st);
        int spd;
        if (frz || dir == 0) n = 0;
        else if (n == 0 || dir != ld) n = 1;
        else if (n < 10000) n = n + 1;
        ld  = dir;
        spd = (n == 0) ? 0 : (1 + (n - 1) / ACCT);
        if (spd > MAXS) spd = MAXS;
        pos = pos + dir * spd;
        if (pos < 0) pos = 0;
        if (pos > lim) pos = lim;
        st = (n == 0) ? int'(IDLE) : ((spd == MAXS) ? int'(CRUISE) : int'(ACCEL));
    endtask

    task automatic eval_tick(input bit l, input bit r, input bit u, input bit d, input bit f);
        int dx, dy;
        dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
        model_axis(dx, f, LIM_X, n_x, ld_x, m_x, st_x);
        model_axis(dy, f, LIM_Y, n_y, ld_y, m_y, st_y);
        check_value("x", int'(sprite_x), m_x);
        check_value("y", int'(sprite_y), m_y);
        check_value("state_x", int'(u_dut.w_state_x), st_x);
        check_value("state_y", int'(u_dut.w_state_y), st_y);
        check_value("moving", int'(moving), int'(st_x != int'(IDLE) || st_y != int'(IDLE)));
        check_value("at_edge", int'(at_edge),
                    {28'd0, m_y == LIM_Y, m_y == 0, m_x == LIM_X, m_x == 0});
    endtask

    // Inputs change just after a tick edge; the next tick edge is TDIV edges away
    task automatic apply_tick(input bit l, input bit r, input bit u, input bit d, input bit f);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; freeze = f;
        repeat (TDIV) @(posedge clk25);
        #1;
        eval_tick(l, r, u, d, f);
    endtask

    initial begin
        int sx, sy;
        bit rl, rr, ru, rd, rf;
        rst_n = 1'b0;
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; freeze = 0;
        repeat (2) @(posedge clk25);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk25);
        #3 rst_n = 1'b0;
        #1;
        check_value("rst_x", int'(sprite_x), 304);
        check_value("rst_y", int'(sprite_y), 400);
        check_value("rst_moving", int'(moving), 0);
        check_value("rst_at_edge", int'(at_edge), 0);
        btn_right = 1'b1;
        repeat (2) @(posedge clk25);
        #1 rst_n = 1'b1;
        repeat (TDIV - 1) @(posedge clk25);
        #1;
        check_value("no_partial_tick", int'(sprite_x), 304);
        @(posedge clk25);
        #1;
        eval_tick(0, 1, 0, 0, 0);
        check_value("first_tick_x", int'(sprite_x), 305);

        for (int i = 0; i < 7; i++) apply_tick(0, 1, 0, 0, 0);
        check_value("x_after8", int'(sprite_x), 322);
        check_value("cruise_after8", int'(u_dut.w_state_x), int'(CRUISE));

        apply_tick(1, 1, 0, 0, 0);
        check_value("both_x", int'(sprite_x), 322);
        check_value("both_idle", int'(u_dut.w_state_x), int'(IDLE));
        apply_tick(1, 0, 0, 0, 0);
        check_value("left_x", int'(sprite_x), 321);
        check_value("left_accel", int'(u_dut.w_state_x), int'(ACCEL));

        for (int i = 0; i < 115; i++) apply_tick(1, 0, 0, 0, 0);
        check_value("clamp_x0", int'(sprite_x), 0);
        check_value("edge_left", int'(at_edge[0]), 1);
        check_value("clamp_cruise", int'(u_dut.w_state_x), int'(CRUISE));

        for (int i = 0; i < 6; i++) apply_tick(0, 1, 1, 0, 0);
        sx = int'(sprite_x);
        sy = int'(sprite_y);
        apply_tick(0, 1, 1, 0, 1);
        check_value("freeze_x", int'(sprite_x), sx);
        check_value("freeze_y", int'(sprite_y), sy);
        apply_tick(0, 1, 1, 0, 0);
        check_value("resume_x", int'(sprite_x), sx + 1);
        check_value("resume_y", int'(sprite_y), sy - 1);

        apply_tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) apply_tick(0, 0, 0, 1, 0);
        check_value("clamp_y448", int'(sprite_y), 448);
        check_value("edge_bottom", int'(at_edge[3]), 1);
        apply_tick(0, 0, 1, 0, 0);
        check_value("y447", int'(sprite_y), 447);
        for (int i = 0; i < 3; i++) apply_tick(0, 0, 0, 1, 0);
        check_value("y_stays448", int'(sprite_y), 448);
        check_value("edge_bottom2", int'(at_edge[3]), 1);

        rl = 0; rr = 0; ru = 0; rd = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) rl = ~rl;
            if ($urandom_range(3) == 0) rr = ~rr;
            if ($urandom_range(3) == 0) ru = ~ru;
            if ($urandom_range(3) == 0) rd = ~rd;
            rf = ($urandom_range(9) == 0);
            apply_tick(rl, rr, ru, rd, rf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_motion_controller.md
# sprite_motion_controller

Parametrised player-sprite motion engine for the 640x480 VGA game pipeline. It samples four direction buttons and produces the sprite's top-left pixel coordinate for the renderer. Motion is tick-paced, accelerates per axis up to a configurable top speed, is clamped to the visible screen, and can be frozen, for example during pause or game-over.

## Interface
Parameters:
- `COORD_W`, 10: coordinate width in bits.
- `SCREEN_W` / `SCREEN_H`, 640 / 480: visible area in pixels.
- `SPRITE_W` / `SPRITE_H`, 32 / 32: sprite size in pixels.
- `START_X` / `START_Y`, 304 / 400: reset position. Must satisfy 0 ≤ START ≤ SCREEN−SPRITE.
- `TICK_DIV`, 131072: clk25 cycles per motion tick. Must be ≥ 2.
- `MAX_SPEED`, 4: top speed in pixels per tick. Must be ≥ 1. MAX_SPEED=1 gives the legacy constant-speed behaviour.
- `ACCEL_TICKS`, 8: held ticks per +1 speed step. Must be ≥ 1.

Ports:
- `clk25`  in  1  pixel clock, 25 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`  in  1 each  raw buttons, asynchronous to clk25.
- `freeze`  in  1  hold position and zero speeds.
- `sprite_x`  out  COORD_W  top-left X.
- `sprite_y`  out  COORD_W  top-left Y.
- `moving`  out  1  either axis not IDLE.
- `at_edge`  out  4  {bottom, top, right, left} contact flags.

## Operation
- Buttons pass through a 2-FF synchroniser per input; the synchroniser flops reset to 0.
- Tick counter counts 0..TICK_DIV−1 and wraps. `tick` is high for the one cycle in which count == TICK_DIV−1. The counter runs regardless of `freeze`.
- Per-axis direction: negative button only → −1; positive button only → +1; both or neither → 0.
- Per-axis FSM with states IDLE, ACCEL and CRUISE, plus registers `speed` (0..MAX_SPEED), `hold` (0..ACCEL_TICKS−1) and `last_dir`. All evaluation happens on `tick` only.
  - `freeze`=1 or dir=0: speed←0, hold←0, go to IDLE. Position is unchanged.
  - dir≠0 and (state IDLE or dir≠last_dir, i.e. a reversal): speed←1, hold←0. Go to CRUISE if MAX_SPEED=1, else ACCEL.
  - dir==last_dir, state ACCEL: hold+1. When hold reaches ACCEL_TICKS−1: hold←0 and speed+1. Go to CRUISE when the new speed equals MAX_SPEED.
  - CRUISE: speed is held at MAX_SPEED.
  - last_dir←dir on every tick.
- Position update uses the speed computed in the same tick (next_speed), so the first tick of a press moves exactly 1 px.
  - The sum pos ± next_speed is computed in COORD_W+2 signed bits.
  - The result is clamped to [0, SCREEN−SPRITE] (X: 0..608, Y: 0..448).
  - Clamping does not alter speed.
- X and Y update in the same cycle. Diagonal motion is independent per axis; there is no normalisation.
- `at_edge` is combinational from the position registers: left = (x==0), right = (x==SCREEN_W−SPRITE_W), top = (y==0), bottom = (y==SCREEN_H−SPRITE_H).

## Timing
- Reset state:
  - sprite_x=START_X, sprite_y=START_Y.
  - speed=0, hold=0, last_dir=0, both axes IDLE.
  - tick counter=0, moving=0.
  - at_edge reflects the start position (0 at defaults).
- Reset deasserted mid-tick-period: the counter restarts from 0. There is no partial tick.
- Latency from a button edge to the first position change: 2 synchroniser cycles plus up to TICK_DIV cycles to the next tick, plus 1 register cycle.
- The position register changes only on the clk25 edge that samples `tick`=1. Between ticks it is stable, so the renderer may sample it at any time.
- Reaching top speed from rest takes 1 + (MAX_SPEED−1)·ACCEL_TICKS ticks of continuous hold.
- A button released and re-pressed between two ticks is not seen; the FSM sees dir only at ticks.

## Structure
- Package `sprite_pkg` holds:
  - the screen constants (640, 480);
  - the axis state enum {IDLE, ACCEL, CRUISE};
  - a function `clamp_coord(signed value, limit)`.
- Sub-module `sprite_axis_motion` contains one axis (FSM, speed, hold, position, clamp). It is parameterised by LIMIT, START, MAX_SPEED and ACCEL_TICKS, and instantiated twice: X with left/right, Y with up/down.
- The top level holds the synchronisers, the tick counter, and the `moving`/`at_edge` logic.

## Test plan
Bench parameters: TICK_DIV=4, MAX_SPEED=3, ACCEL_TICKS=2.
1. Reset: assert rst_n=0 mid-count, then release → x=304, y=400, moving=0, at_edge=0. The first tick arrives exactly 4 cycles after release.
2. Hold btn_right for 8 ticks → per-tick x deltas are 1, 1, 2, 2, 3, 3, 3, 3, ending at x=322. moving=1 throughout, and the FSM enters CRUISE on tick 5.
3. Hold right, then hold left as well (both pressed) for 1 tick, then left only → that tick gives Δx=0 and IDLE. The next tick gives Δx=−1 and ACCEL.
4. Start at x=2, hold left at speed 3 → x goes to 0 (clamped) and stays at 0 with speed held. at_edge[0]=1. No underflow wrap to 1023.
5. Hold up+right at top speed, then pulse freeze for 1 tick → position unchanged on that tick. After freeze drops, motion resumes at speed 1 on both axes.
6. Start y=447, hold down → y=448 and at_edge[3]=1; further ticks keep y=448.
